// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the 8-bit two-register CPU controller:
// instruction field positions, opcode encodings and FSM state encodings.
package cpu_control_unit_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 5;
  localparam int unsigned DST_BIT = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 3'b000,
    OP_LDI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_JMP = 3'b110,
    OP_HLT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  // Extract the opcode field from a raw instruction byte.
  function automatic opcode_t instr_opcode(input logic [DATA_W-1:0] instr);
    return opcode_t'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU: ADD/SUB/AND/OR selected by opcode, 0 otherwise.
// Ports: op (opcode), a/b (operands), result_c (combinational result).
module cpu_alu
  import cpu_control_unit_pkg::*;
(
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result_c
);

  // Arithmetic wraps modulo 2^8; no carry/borrow is kept.
  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:  result_c = a + b;
      OP_SUB:  result_c = a - b;
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit two-register CPU.
// Ports: clk/rst_n; imem_addr/imem_rdata (synchronous-read program memory,
// addr == PC); temp1/temp2 (register file r0/r1); reg_sel/reg_we/reg_wdata
// (register file write port, decoded within the cycle); halted; instr_done.
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] temp1,
  input  logic [DATA_W-1:0] temp2,
  output logic              reg_sel,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              halted,
  output logic              instr_done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  opcode_t           ir_op_q, ir_op_d;
  logic              ir_dst_q, ir_dst_d;
  opcode_t           fetched_op;
  logic [DATA_W-1:0] alu_result;

  assign imem_addr  = pc_q;
  assign fetched_op = instr_opcode(imem_rdata);

  cpu_alu u_alu (
    .op       (ir_op_q),
    .a        (temp1),
    .b        (temp2),
    .result_c (alu_result)
  );

  // State, PC and IR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= ADDR_W'(RESET_PC);
      ir_op_q  <= OP_NOP;
      ir_dst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_op_q  <= ir_op_d;
      ir_dst_q <= ir_dst_d;
    end
  end

  // Next-state and write-port decode. Write outputs come purely from the
  // state register, so they drop the instant rst_n falls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_op_d    = ir_op_q;
    ir_dst_d   = ir_dst_q;
    reg_we     = 1'b0;
    reg_sel    = 1'b0;
    reg_wdata  = '0;
    halted     = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end

      // Decision uses the memory data directly; IR is latched for later states.
      S_DECODE: begin
        ir_op_d  = fetched_op;
        ir_dst_d = imem_rdata[DST_BIT];
        case (fetched_op)
          OP_NOP: begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_LDI, OP_JMP: begin
            // Operand address is already on imem_addr; step past it.
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_OPERAND;
          end
          OP_HLT: begin
            instr_done = 1'b1;
            state_d    = S_HALT;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_OPERAND: begin
        instr_done = 1'b1;
        state_d    = S_FETCH;
        if (ir_op_q == OP_LDI) begin
          reg_we    = 1'b1;
          reg_sel   = ir_dst_q;
          reg_wdata = imem_rdata;
        end else if (ir_op_q == OP_JMP) begin
          pc_d = ADDR_W'(imem_rdata);
        end
      end

      S_EXEC: begin
        instr_done = 1'b1;
        reg_we     = 1'b1;
        reg_sel    = ir_dst_q;
        reg_wdata  = alu_result;
        state_d    = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

endmodule
